// File: rtl/awmc_pkg.sv
// Shared types for the washing-machine cycle sequencer:
// stage codes, program codes and rinse counts per program.
package awmc_pkg;

  typedef enum logic [2:0] {
    FILL  = 3'd0,
    WASH  = 3'd1,
    RINSE = 3'd2,
    SPIN  = 3'd3,
    STOP  = 3'd4,
    DRAIN = 3'd5,
    FAULT = 3'd6,
    IDLE  = 3'd7
  } stage_e;

  typedef enum logic [1:0] {
    PROG_QUICK  = 2'd0,
    PROG_NORMAL = 2'd1,
    PROG_HEAVY  = 2'd2
  } prog_e;

  localparam logic [1:0] RINSES_QUICK  = 2'd1;
  localparam logic [1:0] RINSES_NORMAL = 2'd2;
  localparam logic [1:0] RINSES_HEAVY  = 2'd3;

  // Code 3 is not a real program; it runs as normal.
  function automatic prog_e prog_decode(
    input logic [1:0] sel
  );
    case (sel)
      2'd0:    return PROG_QUICK;
      2'd2:    return PROG_HEAVY;
      default: return PROG_NORMAL;
    endcase
  endfunction

  function automatic logic [1:0] rinse_count(
    input prog_e p
  );
    case (p)
      PROG_QUICK: return RINSES_QUICK;
      PROG_HEAVY: return RINSES_HEAVY;
      default:    return RINSES_NORMAL;
    endcase
  endfunction

endpackage

// File: rtl/stage_timer.sv
// Per-stage cycle counter with synchronous clear, enable
// and a terminal match against a caller-supplied limit.
module stage_timer #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  input  logic [CW-1:0] limit,
  output logic          match
);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  assign match = (count == limit);

endmodule

// File: rtl/wash_cycle_sequencer.sv
// Program-driven washer sequencer: FILL/WASH/DRAIN/RINSE/
// SPIN/STOP with sensor handshakes and timeout faults.
module wash_cycle_sequencer
  import awmc_pkg::*;
#(
  parameter int T_WASH_QUICK  = 6,
  parameter int T_WASH_NORMAL = 10,
  parameter int T_WASH_HEAVY  = 14,
  parameter int T_RINSE       = 4,
  parameter int T_SPIN        = 8,
  parameter int T_STOP        = 2,
  parameter int TIMEOUT       = 20,
  parameter int CW            = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic [1:0] program_sel,
  input  logic       door_closed,
  input  logic       level_full,
  input  logic       level_empty,
  output logic [2:0] stage,
  output logic       input_valve,
  output logic       output_drain,
  output logic       motor_en,
  output logic       door_lock,
  output logic       done,
  output logic       fault
);

  stage_e        stage_q, stage_d;
  prog_e         prog_q, prog_d;
  logic          phase_q, phase_d;
  logic [1:0]    rinse_q, rinse_d;
  logic          done_q, done_d;
  logic          seen_q, seen_d;

  logic          active;
  logic          hold;
  logic          door_trip;
  logic          t_clr;
  logic          match;
  logic [CW-1:0] limit;
  logic [CW-1:0] wash_lim;

  assign active    = (stage_q != IDLE) &&
                     (stage_q != FAULT);
  assign hold      = active && pause;
  assign door_trip = active && !door_closed &&
                     (stage_q != STOP);

  always_comb begin
    wash_lim = CW'(T_WASH_NORMAL - 1);
    case (prog_q)
      PROG_QUICK: wash_lim = CW'(T_WASH_QUICK - 1);
      PROG_HEAVY: wash_lim = CW'(T_WASH_HEAVY - 1);
      default:    wash_lim = CW'(T_WASH_NORMAL - 1);
    endcase
  end

  // Sensor waits share the timeout limit; timed stages
  // use their own duration.
  always_comb begin
    limit = CW'(TIMEOUT - 1);
    unique case (stage_q)
      WASH:  limit = wash_lim;
      RINSE: limit = phase_q ? CW'(T_RINSE - 1)
                             : CW'(TIMEOUT - 1);
      SPIN:  limit = CW'(T_SPIN - 1);
      STOP:  limit = CW'(T_STOP - 1);
      default: limit = CW'(TIMEOUT - 1);
    endcase
  end

  always_comb begin
    stage_d = stage_q;
    prog_d  = prog_q;
    phase_d = phase_q;
    rinse_d = rinse_q;
    done_d  = done_q;
    seen_d  = seen_q;
    if (door_trip) begin
      stage_d = FAULT;
    end else if (!hold) begin
      unique case (stage_q)
        IDLE: begin
          if (start && !pause && door_closed) begin
            stage_d = FILL;
            phase_d = 1'b0;
            prog_d  = prog_decode(program_sel);
            rinse_d = rinse_count(
                        prog_decode(program_sel));
            done_d  = 1'b0;
          end
        end
        FILL: begin
          if (level_full) stage_d = WASH;
          else if (match) stage_d = FAULT;
        end
        WASH: begin
          if (match) stage_d = DRAIN;
        end
        DRAIN: begin
          if (level_empty) begin
            stage_d = (rinse_q != 2'd0) ? RINSE : SPIN;
            phase_d = 1'b0;
          end else if (match) begin
            stage_d = FAULT;
          end
        end
        RINSE: begin
          if (!phase_q) begin
            if (level_full) phase_d = 1'b1;
            else if (match) stage_d = FAULT;
          end else if (match) begin
            rinse_d = rinse_q - 2'd1;
            phase_d = 1'b0;
            stage_d = DRAIN;
          end
        end
        SPIN: begin
          if (match) stage_d = STOP;
        end
        STOP: begin
          if (match) begin
            stage_d = IDLE;
            done_d  = 1'b1;
          end
        end
        FAULT: begin
          if (level_empty) seen_d = 1'b1;
        end
        default: stage_d = FAULT;
      endcase
    end
  end

  assign t_clr = !active ||
                 (stage_d != stage_q) ||
                 (phase_d != phase_q);

  stage_timer #(
    .CW(CW)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (t_clr),
    .enable (!hold),
    .limit  (limit),
    .match  (match)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= IDLE;
      prog_q  <= PROG_QUICK;
      phase_q <= 1'b0;
      rinse_q <= 2'd0;
      done_q  <= 1'b0;
      seen_q  <= 1'b0;
    end else begin
      stage_q <= stage_d;
      prog_q  <= prog_d;
      phase_q <= phase_d;
      rinse_q <= rinse_d;
      done_q  <= done_d;
      seen_q  <= seen_d;
    end
  end

  always_comb begin
    stage        = stage_q;
    input_valve  = 1'b0;
    output_drain = 1'b0;
    motor_en     = 1'b0;
    done         = done_q;
    fault        = (stage_q == FAULT);
    door_lock    = active ||
                   ((stage_q == FAULT) && !seen_q);
    if (!hold) begin
      unique case (stage_q)
        FILL:  input_valve = 1'b1;
        WASH:  motor_en = 1'b1;
        DRAIN: output_drain = 1'b1;
        RINSE: begin
          input_valve = !phase_q;
          motor_en    = phase_q;
        end
        SPIN: begin
          output_drain = 1'b1;
          motor_en     = 1'b1;
        end
        FAULT: output_drain = !seen_q;
        default: ;
      endcase
    end
  end

endmodule
